wl_pulse_seq_ctrl: RTL and testbench
====================================

Name: wl_pulse_seq_ctrl

Overview:
- Parametrised word-line sequencer for the memristor array.
- Accepts a read or write command with row address, WL voltage code and pulse count, and loads the WL DAC.
- Handshakes with the BL/SL controllers, then drives one or more timed WL pulses. Read commands end with an ADC settle window before completion.
- Sits between the top-level op scheduler and the WL DAC/row-decoder interface.

Parameters:
ADDR_W, 5, row address width
DAC_W, 8, WL DAC code width
TMR_W, 8, timer width
CNT_W, 4, pulse-count width
T_DAC, 10, cycles for DAC settle after each lock
T_ADDR, 10, cycles for decoder settle after address latch
T_PULSE, 10, WL high time per pulse
T_GAP, 4, WL low time between write pulses
T_ADC, 10, read-sample window after the pulse

Ports:
sys_clk  in  1  clock
sys_rst_n  in  1  async active-low reset
work_en  in  1  command strobe, accepted only when busy=0
work_mode  in  1  1=write, 0=read
wl_addr_in  in  ADDR_W  row address
wl_vol_in  in  DAC_W  WL pulse voltage code
pulse_num_in  in  CNT_W  write pulse count; 0 is treated as 1; ignored for read
abort  in  1  synchronous abort
bl_over  in  1  BL ready
sl_over  in  1  SL ready (write only)
wl_digital_vol  out  DAC_W  DAC code
wl_dac_lock_en  out  1  one-cycle DAC load strobe
wl_addr  out  ADDR_W  latched row address
wl_pre_op_en  out  1  one-cycle pre-op strobe
wl_addr_op_en  out  1  one-cycle address strobe
wl_assert_en  out  1  WL drive enable
busy  out  1  high outside IDLE
pulse_down  out  1  one-cycle, per completed pulse
op_down_com  out  1  one-cycle, final completion (write: last pulse end; read: ADC end)
read_down  out  1  one-cycle, read completion, same cycle as op_down_com
pulse_idx  out  CNT_W  pulses completed in the current command

Behaviour:
- Reset values: all outputs 0; state IDLE; timer and counters 0.
- Fully synchronous FSM. Every output is registered. No latches, no combinational outputs.
- IDLE:
  - On work_en: latch mode, address, vol and max(pulse_num_in,1).
  - Next cycle: wl_pre_op_en=1, wl_digital_vol=vol, wl_dac_lock_en=1. Go to DAC_SET with timer=T_DAC.
- DAC_SET: count down. At timer==1: wl_addr_op_en=1 for one cycle, go to ADDR_SET with timer=T_ADDR.
- ADDR_SET: count down to 1, then go to WAIT_BLSL.
- WAIT_BLSL: stay until bl_over && (!mode || sl_over). bl_over/sl_over are level-sampled. On the sampled cycle go to PULSE with timer=T_PULSE; wl_assert_en rises the cycle after.
- PULSE: wl_assert_en=1 for exactly T_PULSE cycles. At the end, wl_assert_en=0 next cycle, pulse_down=1, pulse_idx+1.
  - Write with remaining>0: go to GAP with timer=T_GAP.
  - Write with remaining==0: op_down_com=1, go to IDLE.
  - Read: go to ADC_WAIT with timer=T_ADC.
- GAP: count down, then return to PULSE. No new handshake and no DAC reload.
- ADC_WAIT: at end, op_down_com=1 and read_down=1 for one cycle, go to IDLE.
- Command latency, write N pulses, handshake already true: 1+T_DAC+T_ADDR+1+N*T_PULSE+(N-1)*T_GAP cycles from work_en to op_down_com, ±1 for registered edges. The bench checks the exact value computed by the implementation's documented formula.
- Abort:
  - From any non-IDLE state: next cycle wl_assert_en=0 and wl_digital_vol=0 with wl_dac_lock_en=1, go to IDLE.
  - No op_down_com, pulse_down or read_down.
  - Abort wins over a simultaneous terminal event.
- work_en while busy: ignored, inputs not relatched.
- Timers are TMR_W wide, load a parameter, decrement to 1. Any T_* parameter of 0 is illegal; generate an elaboration-time error.
- Reset mid-operation: all outputs 0 immediately (async), FSM returns to IDLE.

Optional Feature:
WL_TIMEOUT_EN.
- Defined: adds parameter T_TIMEOUT (default 255) and output timeout_err (1 bit, reset 0).
- If WAIT_BLSL lasts T_TIMEOUT cycles: timeout_err=1 for one cycle, then abort-style exit (wl_digital_vol=0 with lock, return to IDLE, no completion strobes).
- Undefined: WAIT_BLSL waits indefinitely; no timeout_err port.

Decomposition:
- Package wl_ctrl_pkg: state enum (IDLE, DAC_SET, ADDR_SET, WAIT_BLSL, PULSE, GAP, ADC_WAIT), mode constants MODE_READ=0 and MODE_WRITE=1, default timing constants.
- One sub-module, wl_down_timer: load/decrement/last flag, parameter TMR_W, reused for all windows.

Test Plan:
- Read, addr=5, vol=8'h3C, bl_over tied high: wl_dac_lock_en with 8'h3C; one wl_assert_en window of 10 cycles; after ADC window, op_down_com and read_down together for 1 cycle; sl_over ignored.
- Write, pulse_num=3, bl_over/sl_over high: three 10-cycle assert windows separated by 4-cycle gaps; pulse_down ×3; pulse_idx ends 3; op_down_com once; read_down never.
- Write, pulse_num=0: exactly one pulse.
- Write, sl_over held low 20 cycles after bl_over: no assert until the cycle after sl_over rises; busy high throughout.
- Abort in the 5th cycle of pulse 2 of 3: wl_assert_en low next cycle; wl_digital_vol=0 with lock strobe; no op_down_com; busy drops.
- work_en pulsed mid-command with a new address: wl_addr unchanged.
- Async reset mid-PULSE: all outputs 0 immediately.
- WL_TIMEOUT_EN defined, T_TIMEOUT=16, bl_over low: timeout_err at cycle 16 of WAIT_BLSL, then IDLE.

Source files
------------

// File: rtl/wl_ctrl_pkg.sv
// Shared types and default timing for the word-line pulse sequencer.
package wl_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DAC_SET   = 3'd1,
    ADDR_SET  = 3'd2,
    WAIT_BLSL = 3'd3,
    PULSE     = 3'd4,
    GAP       = 3'd5,
    ADC_WAIT  = 3'd6
  } wl_state_e;

  localparam logic MODE_READ  = 1'b0;
  localparam logic MODE_WRITE = 1'b1;

  localparam int DEF_T_DAC     = 10;
  localparam int DEF_T_ADDR    = 10;
  localparam int DEF_T_PULSE   = 10;
  localparam int DEF_T_GAP     = 4;
  localparam int DEF_T_ADC     = 10;
  localparam int DEF_T_TIMEOUT = 255;

endpackage

// File: rtl/wl_down_timer.sv
// Loadable down-counter shared by every timed window of the sequencer.
// A window of length T is loaded with T and ends in the cycle where last=1,
// so it spans exactly T cycles.
module wl_down_timer #(
  parameter int TMR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [TMR_W-1:0] load_val,
  output logic             last
);

  logic [TMR_W-1:0] cnt_q, cnt_d;

  // Load wins; otherwise count down and rest at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last = (cnt_q == {{(TMR_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/wl_pulse_seq_ctrl.sv
// Word-line pulse sequencer: loads the WL DAC, strobes the row decoder,
// waits for the BL/SL controllers, then drives timed WL pulses.
// Optional build macro WL_TIMEOUT_EN adds a WAIT_BLSL timeout (T_TIMEOUT,
// output timeout_err).
// Timing: for a write of N pulses with the handshake already true,
// op_down_com is high in cycle 1+T_DAC+T_ADDR+1+N*T_PULSE+(N-1)*T_GAP,
// counting the cycle in which work_en is presented as cycle 0.
// Handshake: work_en is a single-cycle request honoured only while busy=0;
// bl_over/sl_over are levels sampled in WAIT_BLSL; all outputs are registered.
module wl_pulse_seq_ctrl import wl_ctrl_pkg::*; #(
  parameter int ADDR_W    = 5,
  parameter int DAC_W     = 8,
  parameter int TMR_W     = 8,
  parameter int CNT_W     = 4,
  parameter int T_DAC     = DEF_T_DAC,
  parameter int T_ADDR    = DEF_T_ADDR,
  parameter int T_PULSE   = DEF_T_PULSE,
  parameter int T_GAP     = DEF_T_GAP,
  parameter int T_ADC     = DEF_T_ADC
`ifdef WL_TIMEOUT_EN
  ,
  parameter int T_TIMEOUT = DEF_T_TIMEOUT
`endif
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              work_en,
  input  logic              work_mode,
  input  logic [ADDR_W-1:0] wl_addr_in,
  input  logic [DAC_W-1:0]  wl_vol_in,
  input  logic [CNT_W-1:0]  pulse_num_in,
  input  logic              abort,
  input  logic              bl_over,
  input  logic              sl_over,
  output logic [DAC_W-1:0]  wl_digital_vol,
  output logic              wl_dac_lock_en,
  output logic [ADDR_W-1:0] wl_addr,
  output logic              wl_pre_op_en,
  output logic              wl_addr_op_en,
  output logic              wl_assert_en,
  output logic              busy,
  output logic              pulse_down,
  output logic              op_down_com,
  output logic              read_down,
  output logic [CNT_W-1:0]  pulse_idx,
`ifdef WL_TIMEOUT_EN
  output logic              timeout_err,
`endif
  output wl_state_e         state_dbg
);

  // Zero-length or oversized windows cannot be sequenced.
  if (T_DAC < 1 || T_ADDR < 1 || T_PULSE < 1 || T_GAP < 1 || T_ADC < 1) begin : g_bad_timing
    $error("wl_pulse_seq_ctrl: T_* parameters must be >= 1");
  end
  if (T_DAC >= 2**TMR_W || T_ADDR >= 2**TMR_W || T_PULSE >= 2**TMR_W ||
      T_GAP >= 2**TMR_W || T_ADC >= 2**TMR_W) begin : g_bad_width
    $error("wl_pulse_seq_ctrl: T_* parameter does not fit in TMR_W");
  end
`ifdef WL_TIMEOUT_EN
  if (T_TIMEOUT < 1 || T_TIMEOUT >= 2**TMR_W) begin : g_bad_timeout
    $error("wl_pulse_seq_ctrl: T_TIMEOUT out of range");
  end
`endif

  wl_state_e         state_q, state_d;
  logic              mode_q, mode_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DAC_W-1:0]  vol_q, vol_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic              lock_q, lock_d;
  logic              pre_op_q, pre_op_d;
  logic              addr_op_q, addr_op_d;
  logic              assert_q, assert_d;
  logic              busy_q, busy_d;
  logic              pdown_q, pdown_d;
  logic              opdone_q, opdone_d;
  logic              rdone_q, rdone_d;
  logic              tout_q, tout_d;

  logic              tmr_load;
  logic [TMR_W-1:0]  tmr_val;
  logic              tmr_last;
  logic [CNT_W:0]    idx_inc;

  wl_down_timer #(.TMR_W(TMR_W)) u_timer (
    .clk      (sys_clk),
    .rst_n    (sys_rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .last     (tmr_last)
  );

  assign idx_inc = {1'b0, idx_q} + {{CNT_W{1'b0}}, 1'b1};

  // Next-state and next-output logic; abort overrides everything outside IDLE.
  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    addr_d    = addr_q;
    vol_d     = vol_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    lock_d    = 1'b0;
    pre_op_d  = 1'b0;
    addr_op_d = 1'b0;
    assert_d  = assert_q;
    pdown_d   = 1'b0;
    opdone_d  = 1'b0;
    rdone_d   = 1'b0;
    tout_d    = 1'b0;
    tmr_load  = 1'b0;
    tmr_val   = '0;

    case (state_q)
      IDLE: begin
        if (work_en) begin
          mode_d   = work_mode;
          addr_d   = wl_addr_in;
          vol_d    = wl_vol_in;
          cnt_d    = (pulse_num_in == '0) ? {{(CNT_W-1){1'b0}}, 1'b1} : pulse_num_in;
          idx_d    = '0;
          pre_op_d = 1'b1;
          lock_d   = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(T_DAC);
          state_d  = DAC_SET;
        end
      end
      DAC_SET: begin
        if (tmr_last) begin
          addr_op_d = 1'b1;
          tmr_load  = 1'b1;
          tmr_val   = TMR_W'(T_ADDR);
          state_d   = ADDR_SET;
        end
      end
      ADDR_SET: begin
        if (tmr_last) begin
          state_d = WAIT_BLSL;
`ifdef WL_TIMEOUT_EN
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(T_TIMEOUT);
`endif
        end
      end
      WAIT_BLSL: begin
        if (bl_over && (mode_q == MODE_READ || sl_over)) begin
          assert_d = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(T_PULSE);
          state_d  = PULSE;
        end
`ifdef WL_TIMEOUT_EN
        else if (tmr_last) begin
          tout_d  = 1'b1;
          vol_d   = '0;
          lock_d  = 1'b1;
          state_d = IDLE;
        end
`endif
      end
      PULSE: begin
        if (tmr_last) begin
          assert_d = 1'b0;
          pdown_d  = 1'b1;
          idx_d    = idx_inc[CNT_W-1:0];
          tmr_load = 1'b1;
          if (mode_q == MODE_WRITE) begin
            if (idx_inc < {1'b0, cnt_q}) begin
              tmr_val = TMR_W'(T_GAP);
              state_d = GAP;
            end else begin
              tmr_load = 1'b0;
              opdone_d = 1'b1;
              state_d  = IDLE;
            end
          end else begin
            tmr_val = TMR_W'(T_ADC);
            state_d = ADC_WAIT;
          end
        end
      end
      GAP: begin
        if (tmr_last) begin
          assert_d = 1'b1;
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(T_PULSE);
          state_d  = PULSE;
        end
      end
      ADC_WAIT: begin
        if (tmr_last) begin
          opdone_d = 1'b1;
          rdone_d  = 1'b1;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (abort && state_q != IDLE) begin
      state_d   = IDLE;
      idx_d     = idx_q;
      assert_d  = 1'b0;
      vol_d     = '0;
      lock_d    = 1'b1;
      addr_op_d = 1'b0;
      pdown_d   = 1'b0;
      opdone_d  = 1'b0;
      rdone_d   = 1'b0;
      tout_d    = 1'b0;
      tmr_load  = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  // State, latched command and registered outputs.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= IDLE;
      mode_q    <= MODE_READ;
      addr_q    <= '0;
      vol_q     <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
      lock_q    <= 1'b0;
      pre_op_q  <= 1'b0;
      addr_op_q <= 1'b0;
      assert_q  <= 1'b0;
      busy_q    <= 1'b0;
      pdown_q   <= 1'b0;
      opdone_q  <= 1'b0;
      rdone_q   <= 1'b0;
      tout_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      addr_q    <= addr_d;
      vol_q     <= vol_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      lock_q    <= lock_d;
      pre_op_q  <= pre_op_d;
      addr_op_q <= addr_op_d;
      assert_q  <= assert_d;
      busy_q    <= busy_d;
      pdown_q   <= pdown_d;
      opdone_q  <= opdone_d;
      rdone_q   <= rdone_d;
      tout_q    <= tout_d;
    end
  end

  assign wl_digital_vol = vol_q;
  assign wl_dac_lock_en = lock_q;
  assign wl_addr        = addr_q;
  assign wl_pre_op_en   = pre_op_q;
  assign wl_addr_op_en  = addr_op_q;
  assign wl_assert_en   = assert_q;
  assign busy           = busy_q;
  assign pulse_down     = pdown_q;
  assign op_down_com    = opdone_q;
  assign read_down      = rdone_q;
  assign pulse_idx      = idx_q;
  assign state_dbg      = state_q;
`ifdef WL_TIMEOUT_EN
  assign timeout_err    = tout_q;
`else
  logic unused_tout;
  assign unused_tout = tout_q;
`endif

endmodule

// File: tb/tb_wl_pulse_seq_ctrl.sv
// Directed bench for wl_pulse_seq_ctrl with an event scoreboard.
// Optional build macro WL_TIMEOUT_EN enables the WAIT_BLSL timeout scenario.
module tb_wl_pulse_seq_ctrl;
  import wl_ctrl_pkg::*;

  localparam int TD = 10;
  localparam int TA = 10;
  localparam int TP = 10;
  localparam int TG = 4;
  localparam int TC = 10;
`ifdef WL_TIMEOUT_EN
  localparam int TT      = 16;
  localparam int SL_HOLD = 12;
`else
  localparam int SL_HOLD = 20;
`endif

  // Event kinds seen by the monitor
  localparam int K_PDOWN = 1, K_OPDONE = 2, K_LOCK = 3, K_RISE = 4, K_FALL = 5;
  localparam int K_TOUT = 6, K_ADDROP = 7, K_RD_ALONE = 8, K_PRE_ALONE = 9;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n, work_en, work_mode, abort, bl_over, sl_over;
  logic [4:0] wl_addr_in, wl_addr;
  logic [7:0] wl_vol_in, wl_digital_vol;
  logic [3:0] pulse_num_in, pulse_idx;
  logic       wl_dac_lock_en, wl_pre_op_en, wl_addr_op_en, wl_assert_en;
  logic       busy, pulse_down, op_down_com, read_down;
  logic       tout_w;
  wl_state_e  state_dbg;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic mon_en = 1'b0;
  logic prev_assert = 1'b0;
  logic [31:0] exp_q[$];

  wl_pulse_seq_ctrl #(
    .ADDR_W(5), .DAC_W(8), .TMR_W(8), .CNT_W(4),
    .T_DAC(TD), .T_ADDR(TA), .T_PULSE(TP), .T_GAP(TG), .T_ADC(TC)
`ifdef WL_TIMEOUT_EN
    , .T_TIMEOUT(TT)
`endif
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .work_en(work_en), .work_mode(work_mode),
    .wl_addr_in(wl_addr_in), .wl_vol_in(wl_vol_in), .pulse_num_in(pulse_num_in),
    .abort(abort), .bl_over(bl_over), .sl_over(sl_over),
    .wl_digital_vol(wl_digital_vol), .wl_dac_lock_en(wl_dac_lock_en), .wl_addr(wl_addr),
    .wl_pre_op_en(wl_pre_op_en), .wl_addr_op_en(wl_addr_op_en), .wl_assert_en(wl_assert_en),
    .busy(busy), .pulse_down(pulse_down), .op_down_com(op_down_com), .read_down(read_down),
    .pulse_idx(pulse_idx),
`ifdef WL_TIMEOUT_EN
    .timeout_err(tout_w),
`endif
    .state_dbg(state_dbg)
  );
`ifndef WL_TIMEOUT_EN
  assign tout_w = 1'b0;
`endif

  // Clock and cycle counter (number of rising edges so far)
  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  function automatic logic [31:0] ev(input int kind, input int c, input int data);
    ev = {kind[3:0], c[15:0], data[11:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic ev_chk(input int kind, input int data);
    logic [31:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
    chk("event", ev(kind, cyc, data), e);
  endtask

  // Monitor: turns output activity into events and checks them in order
  always @(negedge sys_clk) begin
    if (mon_en) begin
      if (wl_dac_lock_en) ev_chk(K_LOCK, {23'd0, wl_pre_op_en, wl_digital_vol});
      if (wl_pre_op_en && !wl_dac_lock_en) ev_chk(K_PRE_ALONE, 0);
      if (wl_addr_op_en) ev_chk(K_ADDROP, {27'd0, wl_addr});
      if (wl_assert_en && !prev_assert) ev_chk(K_RISE, {27'd0, wl_addr});
      if (!wl_assert_en && prev_assert) ev_chk(K_FALL, 0);
      if (pulse_down) ev_chk(K_PDOWN, {28'd0, pulse_idx});
      if (op_down_com) ev_chk(K_OPDONE, {31'd0, read_down});
      if (read_down && !op_down_com) ev_chk(K_RD_ALONE, 0);
      if (tout_w) ev_chk(K_TOUT, 0);
    end
    prev_assert = wl_assert_en;
  end

  task automatic wait_to(input int target);
    while (cyc < target) @(negedge sys_clk);
  endtask

  // Present a command for one cycle; push its DAC-lock and address-strobe events
  task automatic issue(input logic mode, input logic [4:0] addr, input logic [7:0] vol,
                       input logic [3:0] pnum, output int c);
    c = cyc;
    work_en = 1'b1; work_mode = mode; wl_addr_in = addr; wl_vol_in = vol; pulse_num_in = pnum;
    exp_q.push_back(ev(K_LOCK, c + 1, 256 + int'(vol)));
    exp_q.push_back(ev(K_ADDROP, c + 1 + TD, int'(addr)));
    @(negedge sys_clk);
    work_en = 1'b0;
  endtask

  // Push pulse train events starting with the first rise in cycle s0
  task automatic push_pulses(input logic mode, input logic [4:0] addr, input int n,
                             input int s0, output int done);
    int r;
    for (int j = 0; j < n; j++) begin
      r = s0 + j * (TP + TG);
      exp_q.push_back(ev(K_RISE, r, int'(addr)));
      exp_q.push_back(ev(K_FALL, r + TP, 0));
      exp_q.push_back(ev(K_PDOWN, r + TP, j + 1));
    end
    done = s0 + (n - 1) * (TP + TG) + TP;
    if (mode == MODE_WRITE) begin
      exp_q.push_back(ev(K_OPDONE, done, 0));
    end else begin
      done = done + TC;
      exp_q.push_back(ev(K_OPDONE, done, 1));
    end
  endtask

  function automatic logic [31:0] all_outs();
    all_outs = {1'b0, tout_w, state_dbg, wl_digital_vol, wl_dac_lock_en, wl_addr,
                wl_pre_op_en, wl_addr_op_en, wl_assert_en, busy, pulse_down,
                op_down_com, read_down, pulse_idx};
  endfunction

  initial begin
    int c, done, r;
    sys_rst_n = 1'b0; work_en = 1'b0; work_mode = 1'b0; abort = 1'b0;
    bl_over = 1'b1; sl_over = 1'b1; wl_addr_in = '0; wl_vol_in = '0; pulse_num_in = '0;

    // Reset state
    repeat (3) @(negedge sys_clk);
    chk("reset_outputs", all_outs(), 32'd0);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    mon_en = 1'b1;
    chk("idle_after_reset", all_outs(), 32'd0);

    // Read, addr 5, vol 3C; sl_over low must not matter
    sl_over = 1'b0;
    issue(MODE_READ, 5'd5, 8'h3C, 4'd7, c);
    chk("read_busy", {31'd0, busy}, 32'd1);
    push_pulses(MODE_READ, 5'd5, 1, c + TD + TA + 2, done);
    wait_to(done + 2);
    chk("read_queue_empty", exp_q.size(), 32'd0);
    chk("read_idle", {31'd0, busy}, 32'd0);
    sl_over = 1'b1;

    // Write, three pulses
    issue(MODE_WRITE, 5'd9, 8'hA5, 4'd3, c);
    push_pulses(MODE_WRITE, 5'd9, 3, c + TD + TA + 2, done);
    wait_to(done - 1);
    chk("write3_busy_before_end", {31'd0, busy}, 32'd1);
    wait_to(done + 2);
    chk("write3_queue_empty", exp_q.size(), 32'd0);
    chk("write3_pulse_idx", {28'd0, pulse_idx}, 32'd3);
    chk("write3_idle", {31'd0, busy}, 32'd0);

    // Write with pulse count 0 behaves as one pulse
    issue(MODE_WRITE, 5'd17, 8'h11, 4'd0, c);
    push_pulses(MODE_WRITE, 5'd17, 1, c + TD + TA + 2, done);
    wait_to(done + 2);
    chk("write0_queue_empty", exp_q.size(), 32'd0);
    chk("write0_pulse_idx", {28'd0, pulse_idx}, 32'd1);

    // Write with SL late: no assert until the cycle after sl_over rises
    sl_over = 1'b0;
    issue(MODE_WRITE, 5'd30, 8'h5A, 4'd1, c);
    r = c + 1 + TD + TA + SL_HOLD;
    push_pulses(MODE_WRITE, 5'd30, 1, r + 1, done);
    while (cyc < r) begin
      chk("sl_wait_busy", {30'd0, busy, wl_assert_en}, 32'd2);
      @(negedge sys_clk);
    end
    sl_over = 1'b1;
    wait_to(done + 2);
    chk("sl_wait_queue_empty", exp_q.size(), 32'd0);

    // Abort during the 5th cycle of pulse 2 of 3
    issue(MODE_WRITE, 5'd3, 8'h77, 4'd3, c);
    r = c + TD + TA + 2;
    exp_q.push_back(ev(K_RISE, r, 3));
    exp_q.push_back(ev(K_FALL, r + TP, 0));
    exp_q.push_back(ev(K_PDOWN, r + TP, 1));
    r = r + TP + TG;
    exp_q.push_back(ev(K_RISE, r, 3));
    exp_q.push_back(ev(K_LOCK, r + 5, 0));
    exp_q.push_back(ev(K_FALL, r + 5, 0));
    wait_to(r + 4);
    abort = 1'b1;
    @(negedge sys_clk);
    abort = 1'b0;
    chk("abort_outputs", {wl_digital_vol, wl_dac_lock_en, wl_assert_en, busy}, 32'h004);
    repeat (30) @(negedge sys_clk);
    chk("abort_queue_empty", exp_q.size(), 32'd0);
    chk("abort_pulse_idx", {28'd0, pulse_idx}, 32'd1);

    // New work_en during a command is ignored
    issue(MODE_WRITE, 5'd12, 8'h44, 4'd1, c);
    push_pulses(MODE_WRITE, 5'd12, 1, c + TD + TA + 2, done);
    wait_to(c + 5);
    work_en = 1'b1; work_mode = MODE_READ; wl_addr_in = 5'd20; wl_vol_in = 8'hFF; pulse_num_in = 4'd5;
    @(negedge sys_clk);
    work_en = 1'b0;
    chk("relatch_addr", {27'd0, wl_addr}, 32'd12);
    chk("relatch_vol", {24'd0, wl_digital_vol}, 32'h44);
    wait_to(done + 2);
    chk("relatch_queue_empty", exp_q.size(), 32'd0);

    // Asynchronous reset in the middle of a pulse
    issue(MODE_READ, 5'd7, 8'h99, 4'd1, c);
    r = c + TD + TA + 2;
    exp_q.push_back(ev(K_RISE, r, 7));
    wait_to(r + 3);
    chk("pre_reset_assert", {31'd0, wl_assert_en}, 32'd1);
    #2 sys_rst_n = 1'b0;
    #1 chk("async_reset_outputs", all_outs(), 32'd0);
    mon_en = 1'b0;
    chk("async_reset_queue_empty", exp_q.size(), 32'd0);
    exp_q.delete();
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    mon_en = 1'b1;
    chk("after_reset_idle", all_outs(), 32'd0);

`ifdef WL_TIMEOUT_EN
    // BL never ready: timeout after TT cycles of WAIT_BLSL, then abort-style exit
    bl_over = 1'b0;
    issue(MODE_READ, 5'd2, 8'h21, 4'd1, c);
    r = c + 1 + TD + TA + TT;
    exp_q.push_back(ev(K_LOCK, r, 0));
    exp_q.push_back(ev(K_TOUT, r, 0));
    wait_to(r - 1);
    chk("timeout_busy", {31'd0, busy}, 32'd1);
    wait_to(r + 3);
    chk("timeout_idle", {31'd0, busy}, 32'd0);
    chk("timeout_queue_empty", exp_q.size(), 32'd0);
    bl_over = 1'b1;
`endif

    repeat (3) @(negedge sys_clk);
    chk("final_queue_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
